// File: rtl/fft_frame_reader.sv
// Accepts one FFT frame sample per cycle, rounds and saturates it to the output width,
// and tracks the frame's L1 peak. Samples are queued for downstream in a first-word-fall-through FIFO.
module fft_frame_reader #(
    parameter int SIZE_BUFFER   = 8,
    parameter int SIZE_DATA_IN  = 22,
    parameter int SIZE_DATA_OUT = 16,
    parameter int FIFO_LOG2     = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_complete,
    input  logic signed [SIZE_DATA_IN-1:0]  i_data_in_i,
    input  logic signed [SIZE_DATA_IN-1:0]  i_data_in_q,
    output logic                            o_flag_ready_recive,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic signed [SIZE_DATA_OUT-1:0] o_data_i,
    output logic signed [SIZE_DATA_OUT-1:0] o_data_q,
    output logic [SIZE_BUFFER-1:0]          o_bin,
    output logic                            o_last,
    output logic                            o_peak_valid,
    output logic [SIZE_BUFFER-1:0]          o_peak_bin,
    output logic [SIZE_DATA_OUT:0]          o_peak_mag,
    output logic                            o_err_drop
);

    localparam int SHIFT   = SIZE_DATA_IN - SIZE_DATA_OUT;
    localparam int DEPTH   = 1 << FIFO_LOG2;
    localparam int CNT_W   = FIFO_LOG2 + 1;
    localparam int MAG_W   = SIZE_DATA_OUT + 1;
    localparam int ENTRY_W = 2 * SIZE_DATA_OUT + SIZE_BUFFER + 1;

    localparam logic signed [SIZE_DATA_IN:0] ROUND_K = (SIZE_DATA_IN + 1)'(1) << (SHIFT - 1);
    localparam logic [CNT_W-1:0]             READY_MAX = CNT_W'(DEPTH - 2);

    typedef enum logic {
        S_IDLE,
        S_RECV
    } state_t;

    // Round half up, then clamp only the positive side; the most negative input
    // still lands inside the output range after the shift.
    function automatic logic signed [SIZE_DATA_OUT-1:0] scale_sat(
        input logic signed [SIZE_DATA_IN-1:0] x
    );
        logic signed [SIZE_DATA_IN:0] sum;
        logic signed [SIZE_DATA_IN:0] shr;
        sum = $signed({x[SIZE_DATA_IN-1], x}) + ROUND_K;
        shr = sum >>> SHIFT;
        if (!shr[SIZE_DATA_IN] && (|shr[SIZE_DATA_IN-1:SIZE_DATA_OUT-1]))
            scale_sat = {1'b0, {(SIZE_DATA_OUT-1){1'b1}}};
        else
            scale_sat = shr[SIZE_DATA_OUT-1:0];
    endfunction

    function automatic logic [MAG_W-1:0] l1_mag(
        input logic signed [SIZE_DATA_OUT-1:0] a,
        input logic signed [SIZE_DATA_OUT-1:0] b
    );
        logic [SIZE_DATA_OUT-1:0] abs_a;
        logic [SIZE_DATA_OUT-1:0] abs_b;
        abs_a  = a[SIZE_DATA_OUT-1] ? $unsigned(-a) : $unsigned(a);
        abs_b  = b[SIZE_DATA_OUT-1] ? $unsigned(-b) : $unsigned(b);
        l1_mag = {1'b0, abs_a} + {1'b0, abs_b};
    endfunction

    state_t                     state_q, state_d;
    logic [SIZE_BUFFER-1:0]     bin_q, bin_d;
    logic [FIFO_LOG2-1:0]       wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [MAG_W-1:0]           run_mag_q, run_mag_d;
    logic [SIZE_BUFFER-1:0]     run_bin_q, run_bin_d;
    logic [MAG_W-1:0]           peak_mag_q, peak_mag_d;
    logic [SIZE_BUFFER-1:0]     peak_bin_q, peak_bin_d;
    logic                       peak_vld_q, peak_vld_d;
    logic                       err_q, err_d;
    logic [ENTRY_W-1:0]         mem_q [DEPTH];

    logic signed [SIZE_DATA_OUT-1:0] scaled_i;
    logic signed [SIZE_DATA_OUT-1:0] scaled_q;
    logic [MAG_W-1:0]                mag;
    logic                            ready;
    logic                            accept;
    logic                            drop;
    logic                            pop;
    logic                            not_empty;
    logic                            is_last;
    logic                            restart;
    logic [MAG_W-1:0]                cand_mag;
    logic [SIZE_BUFFER-1:0]          cand_bin;
    logic [ENTRY_W-1:0]              entry_in;
    logic [ENTRY_W-1:0]              head;

    // Input stage: scale, magnitude and handshake decode
    assign scaled_i  = scale_sat(i_data_in_i);
    assign scaled_q  = scale_sat(i_data_in_q);
    assign mag       = l1_mag(scaled_i, scaled_q);
    assign ready     = (count_q <= READY_MAX);
    assign not_empty = (count_q != '0);
    assign accept    = i_complete && ready;
    assign drop      = i_complete && !ready;
    assign pop       = not_empty && i_ready;
    assign is_last   = &bin_q;
    assign restart   = accept && (state_q == S_IDLE);
    assign entry_in  = {scaled_i, scaled_q, bin_q, is_last};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !is_last) state_d = S_RECV;
            S_RECV:  if (accept && is_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strictly-greater update keeps the earliest bin on ties
    always_comb begin
        cand_mag = run_mag_q;
        cand_bin = run_bin_q;
        if (restart || (mag > run_mag_q)) begin
            cand_mag = mag;
            cand_bin = bin_q;
        end
    end

    always_comb begin
        bin_d      = bin_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        run_mag_d  = run_mag_q;
        run_bin_d  = run_bin_q;
        peak_mag_d = peak_mag_q;
        peak_bin_d = peak_bin_q;
        peak_vld_d = 1'b0;
        err_d      = err_q | drop;

        if (accept) begin
            bin_d     = bin_q + SIZE_BUFFER'(1);
            wr_ptr_d  = wr_ptr_q + FIFO_LOG2'(1);
            run_mag_d = cand_mag;
            run_bin_d = cand_bin;
            if (is_last) begin
                peak_mag_d = cand_mag;
                peak_bin_d = cand_bin;
                peak_vld_d = 1'b1;
            end
        end

        if (pop)
            rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);

        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Register stage: control, pointers and peak results
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            run_mag_q  <= '0;
            run_bin_q  <= '0;
            peak_mag_q <= '0;
            peak_bin_q <= '0;
            peak_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            run_mag_q  <= run_mag_d;
            run_bin_q  <= run_bin_d;
            peak_mag_q <= peak_mag_d;
            peak_bin_q <= peak_bin_d;
            peak_vld_q <= peak_vld_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept)
            mem_q[wr_ptr_q] <= entry_in;
    end

    // Output stage: head of FIFO, forced to zero whenever nothing is queued
    assign head = mem_q[rd_ptr_q];

    assign o_flag_ready_recive = ready;
    assign o_valid      = not_empty;
    assign o_data_i     = not_empty ? head[ENTRY_W-1 -: SIZE_DATA_OUT] : '0;
    assign o_data_q     = not_empty ? head[SIZE_BUFFER+1 +: SIZE_DATA_OUT] : '0;
    assign o_bin        = not_empty ? head[1 +: SIZE_BUFFER] : '0;
    assign o_last       = not_empty && head[0];
    assign o_peak_valid = peak_vld_q;
    assign o_peak_bin   = peak_bin_q;
    assign o_peak_mag   = peak_mag_q;
    assign o_err_drop   = err_q;

endmodule

// File: tb/tb_fft_frame_reader.sv
// Self-checking bench for fft_frame_reader: scoreboard of expected FIFO entries,
// table-driven rounding vectors, and frame sequences for backpressure, drop, tie and reset.
module tb_fft_frame_reader;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                i_complete;
    logic signed [21:0]  i_data_in_i;
    logic signed [21:0]  i_data_in_q;
    logic                o_flag_ready_recive;
    logic                o_valid;
    logic                i_ready;
    logic signed [15:0]  o_data_i;
    logic signed [15:0]  o_data_q;
    logic [7:0]          o_bin;
    logic                o_last;
    logic                o_peak_valid;
    logic [7:0]          o_peak_bin;
    logic [16:0]         o_peak_mag;
    logic                o_err_drop;

    always #5 clk = ~clk;

    fft_frame_reader #(
        .SIZE_BUFFER(8), .SIZE_DATA_IN(22), .SIZE_DATA_OUT(16), .FIFO_LOG2(4)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_complete(i_complete),
        .i_data_in_i(i_data_in_i),
        .i_data_in_q(i_data_in_q),
        .o_flag_ready_recive(o_flag_ready_recive),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data_i(o_data_i),
        .o_data_q(o_data_q),
        .o_bin(o_bin),
        .o_last(o_last),
        .o_peak_valid(o_peak_valid),
        .o_peak_bin(o_peak_bin),
        .o_peak_mag(o_peak_mag),
        .o_err_drop(o_err_drop)
    );

    typedef struct {
        logic signed [15:0] di;
        logic signed [15:0] dq;
        logic [7:0]         bin;
        logic               last;
    } exp_t;

    typedef struct {
        logic signed [21:0] in_i;
        logic signed [21:0] in_q;
        logic signed [15:0] ex_i;
        logic signed [15:0] ex_q;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          mbin = 0;
    logic        exp_pulse = 1'b0;
    logic        drop_seen = 1'b0;
    int          pulses = 0;
    logic [7:0]  pk_bin_seen = '0;
    logic [16:0] pk_mag_seen = '0;
    int          max_occ = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check state, predict this edge's push/pop.
    task automatic cycle(input logic cpl, input logic signed [21:0] di, input logic signed [21:0] dq,
                         input logic signed [15:0] ei, input logic signed [15:0] eq, input logic rdy);
        exp_t e;
        logic model_ready;
        i_complete  = cpl;
        i_data_in_i = di;
        i_data_in_q = dq;
        i_ready     = rdy;
        model_ready = (sb.size() <= 14);
        check("peak_valid", o_peak_valid, exp_pulse);
        if (o_peak_valid) begin
            pulses++;
            pk_bin_seen = o_peak_bin;
            pk_mag_seen = o_peak_mag;
        end
        exp_pulse = 1'b0;
        check("valid", o_valid, sb.size() != 0);
        check("ready", o_flag_ready_recive, model_ready);
        check("err_drop", o_err_drop, drop_seen);
        if (sb.size() > max_occ) max_occ = sb.size();
        if (o_valid && sb.size() > 0) begin
            check("data_i", o_data_i, sb[0].di);
            check("data_q", o_data_q, sb[0].dq);
            check("bin", o_bin, sb[0].bin);
            check("last", o_last, sb[0].last);
            if (rdy) void'(sb.pop_front());
        end
        if (cpl) begin
            if (model_ready) begin
                e = '{ei, eq, 8'(mbin), (mbin == 255)};
                sb.push_back(e);
                if (mbin == 255) exp_pulse = 1'b1;
                mbin = (mbin + 1) % 256;
            end else begin
                drop_seen = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && i >= 2) break;
            cycle(1'b0, '0, '0, '0, '0, 1'b1);
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic check_peak(input string name, input logic [7:0] eb, input logic [16:0] em);
        check({name, "_pulses"}, pulses, 1);
        check({name, "_bin"}, pk_bin_seen, eb);
        check({name, "_mag"}, pk_mag_seen, em);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_data_i"}, o_data_i, 0);
        check({tag, "_data_q"}, o_data_q, 0);
        check({tag, "_bin"}, o_bin, 0);
        check({tag, "_last"}, o_last, 0);
        check({tag, "_peak_valid"}, o_peak_valid, 0);
        check({tag, "_peak_bin"}, o_peak_bin, 0);
        check({tag, "_peak_mag"}, o_peak_mag, 0);
        check({tag, "_err_drop"}, o_err_drop, 0);
    endtask

    task automatic ramp_frame();
        for (int k = 0; k < 256; k++) begin
            cycle(1'b1, 22'(k << 6), '0, 16'(k), '0, 1'b1);
            if (k == 0) check("latency_valid", o_valid, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        logic flag;

        vecs[0] = '{22'sh1FFFDF, -22'sd33,   16'sh7FFF,  -16'sd1};
        vecs[1] = '{22'sd31,     22'sd32,    16'sd0,     16'sd1};
        vecs[2] = '{22'sh1FFFE0, 22'sd0,     16'sh7FFF,  16'sd0};
        vecs[3] = '{22'sh1FFFFF, 22'sd0,     16'sh7FFF,  16'sd0};
        vecs[4] = '{22'sh200000, 22'sd0,     -16'sd32768, 16'sd0};
        vecs[5] = '{-22'sd32,    22'sd33,    16'sd0,     16'sd1};
        vecs[6] = '{-22'sd31,    -22'sd97,   16'sd0,     -16'sd2};
        vecs[7] = '{-22'sd320,   22'sd320,   -16'sd5,    16'sd5};

        rst_n = 1'b0;
        i_complete = 1'b0;
        i_data_in_i = '0;
        i_data_in_q = '0;
        i_ready = 1'b0;
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", o_flag_ready_recive, 1);

        // Rounding and saturation vectors at bins 0..7, rest of frame zero
        pulses = 0;
        for (int i = 0; i < 8; i++)
            cycle(1'b1, vecs[i].in_i, vecs[i].in_q, vecs[i].ex_i, vecs[i].ex_q, 1'b1);
        for (int k = 8; k < 256; k++)
            cycle(1'b1, '0, '0, '0, '0, 1'b1);
        drain();
        check_peak("round_peak", 8'd0, 17'd32768);

        // Plain ramp frame
        pulses = 0;
        ramp_frame();
        drain();
        check_peak("ramp_peak", 8'd255, 17'd255);

        // Backpressure: sink stalls 20 cycles, source honours ready
        pulses = 0;
        max_occ = 0;
        s = 0;
        for (int c = 0; c < 2000 && s < 256; c++) begin
            if (o_flag_ready_recive) begin
                cycle(1'b1, 22'(-(s << 6)), 22'((s << 6) + 31), 16'(-s), 16'(s), c >= 20);
                s++;
            end else begin
                cycle(1'b0, '0, '0, '0, '0, c >= 20);
            end
        end
        check("bp_all_sent", s, 256);
        drain();
        check("bp_max_occupancy", max_occ, 15);
        check("bp_no_drop", o_err_drop, 0);
        check_peak("bp_peak", 8'd255, 17'd510);

        // Drop: source ignores ready while the sink stalls
        pulses = 0;
        s = 0;
        for (int c = 0; c < 2000 && s < 256; c++) begin
            flag = o_flag_ready_recive;
            cycle(1'b1, 22'(s << 6), '0, 16'(s), '0, c >= 20);
            if (flag) s++;
        end
        check("drop_all_sent", s, 256);
        drain();
        check("drop_sticky", o_err_drop, 1);
        check_peak("drop_peak", 8'd255, 17'd255);

        // Tie: magnitude 100 at bins 7 and 40
        pulses = 0;
        for (int k = 0; k < 256; k++) begin
            if (k == 7)
                cycle(1'b1, 22'(60 << 6), 22'(-(40 << 6)), 16'sd60, -16'sd40, 1'b1);
            else if (k == 40)
                cycle(1'b1, '0, 22'(100 << 6), '0, 16'sd100, 1'b1);
            else
                cycle(1'b1, 22'((k % 50) << 6), '0, 16'(k % 50), '0, 1'b1);
        end
        drain();
        check_peak("tie_peak", 8'd7, 17'd100);

        // Reset in the middle of a frame
        for (int k = 0; k <= 100; k++)
            cycle(1'b1, 22'(k << 6), '0, 16'(k), '0, 1'b1);
        i_complete = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        sb.delete();
        mbin = 0;
        drop_seen = 1'b0;
        exp_pulse = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", o_flag_ready_recive, 1);
        pulses = 0;
        cycle(1'b1, 22'sd0, '0, 16'sd0, '0, 1'b0);
        check("post_reset_bin", o_bin, 0);
        for (int k = 1; k < 256; k++)
            cycle(1'b1, 22'(k << 6), '0, 16'(k), '0, 1'b1);
        drain();
        check_peak("post_reset_peak", 8'd255, 17'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
